// File: rtl/cms_pkg.sv
// Shared definitions for the trace streamer:
//   - control register addresses and CTRL bit positions
//   - filter mode and controller state encodings
//   - RISC-V control-flow opcodes and the WFI encoding
//   - filter_pass(): instruction-class filter applied at capture
package cms_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_START    = 8'h01;
    localparam logic [7:0] ADDR_STOP     = 8'h02;
    localparam logic [7:0] ADDR_TLAST    = 8'h03;
    localparam logic [7:0] ADDR_DROP_CLR = 8'h04;

    localparam int CTRL_ARM     = 0;
    localparam int CTRL_TRIG_EN = 1;
    localparam int CTRL_FLUSH   = 2;
    localparam int CTRL_DEDUP   = 3;
    localparam int CTRL_FILT_LO = 4;
    localparam int CTRL_FILT_HI = 5;

    typedef enum logic [1:0] {
        FILT_ALL    = 2'd0,
        FILT_CFLOW  = 2'd1,
        FILT_NO_WFI = 2'd2,
        FILT_RSVD   = 2'd3
    } filter_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_TRACING  = 2'd2,
        ST_DRAINING = 2'd3
    } state_e;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [31:0] INSTR_WFI  = 32'h1050_0073;

    // The reserved mode behaves like FILT_ALL.
    function automatic logic filter_pass(filter_e mode, logic [31:0] ins);
        logic ok;
        ok = 1'b1;
        case (mode)
            FILT_CFLOW:  ok = (ins[6:0] == OPC_BRANCH) || (ins[6:0] == OPC_JAL) ||
                              (ins[6:0] == OPC_JALR);
            FILT_NO_WFI: ok = (ins != INSTR_WFI);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cms_sync_fifo.sv
// Synchronous FIFO with a per-entry tlast mark bit.
//   push_i/data_i       write an entry (ignored when full unless popping)
//   pop_i               remove the head entry
//   mark_tail_i         set the mark bit of the newest stored entry
//   data_o/mark_o       head entry (valid while !empty_o)
//   full_o/empty_o/count_o occupancy
module cms_sync_fifo
    import cms_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     mark_tail_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     mark_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] mark_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    tail_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign count_o  = count_q;
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    // Depth is a power of two, so the pointer wraps naturally.
    assign tail_ptr = wr_ptr_q - 1'b1;
    assign data_o   = mem_q[rd_ptr_q];
    assign mark_o   = mark_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mark_q   <= '0;
        end else begin
            if (mark_tail_i && !empty_o) begin
                mark_q[tail_ptr] <= 1'b1;
            end
            if (do_push) begin
                mark_q[wr_ptr_q] <= 1'b0;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cms_trace_streamer.sv
// Trace capture and AXI-Stream streamer.
//   clk, rst_n                 clock, async active-low reset
//   pc, instr, pc_valid, en    retired instruction stream and global enable
//   ctrl_addr/wdata/write_enable  control register writes
//   M_AXIS_*                   record stream {pad, instr, pc}
//   dropped_count              records lost to a full buffer (saturating)
//   busy                       controller active or buffer not empty
//
// state       | meaning
// ST_IDLE     | not tracing; waits for arm
// ST_ARMED    | waiting for a valid pc equal to START_ADDR
// ST_TRACING  | capturing qualifying records
// ST_DRAINING | capture stopped; streaming out what is buffered
module cms_trace_streamer
    import cms_pkg::*;
#(
    parameter int XLEN                                = 64,
    parameter int AXI_DATA_WIDTH                      = 96,
    parameter int FIFO_DEPTH                          = 16,
    parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               instr,
    input  logic [XLEN-1:0]           pc,
    input  logic                      pc_valid,
    input  logic                      en,
    input  logic [7:0]                ctrl_addr,
    input  logic [63:0]               ctrl_wdata,
    input  logic                      ctrl_write_enable,
    output logic                      M_AXIS_tvalid,
    input  logic                      M_AXIS_tready,
    output logic [AXI_DATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                      M_AXIS_tlast,
    output logic [31:0]               dropped_count,
    output logic                      busy
);

    localparam int REC_W = XLEN + 32;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic              arm_q, trig_en_q, dedup_q;
    filter_e           filter_q;
    logic [XLEN-1:0]   start_q, stop_q, last_pc_q;
    logic [31:0]       interval_q, beat_cnt_q, dropped_q;

    logic              wr_fire, wr_ctrl, flush_pulse, drop_clr;
    logic              pc_hit_start, pc_hit_stop, qualify;
    logic              capture, arm_clr;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_mark, drop;
    logic [REC_W-1:0]  fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              int_hit, tlast_int;

    generate
        if (CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) begin : g_we_edge
            logic we_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) we_q <= 1'b0;
                else        we_q <= ctrl_write_enable;
            end
            assign wr_fire = ctrl_write_enable && !we_q;
        end else begin : g_we_level
            assign wr_fire = ctrl_write_enable;
        end
    endgenerate

    assign wr_ctrl     = wr_fire && (ctrl_addr == ADDR_CTRL);
    assign flush_pulse = wr_ctrl && ctrl_wdata[CTRL_FLUSH];
    assign drop_clr    = wr_fire && (ctrl_addr == ADDR_DROP_CLR);

    assign pc_hit_start = pc_valid && (pc == start_q);
    assign pc_hit_stop  = pc_valid && (pc == stop_q);
    assign qualify      = pc_valid && en && filter_pass(filter_q, instr) &&
                          !(dedup_q && (pc == last_pc_q));

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_q) state_d = trig_en_q ? ST_ARMED : ST_TRACING;
            end
            ST_ARMED: begin
                if (!arm_q)            state_d = ST_IDLE;
                else if (pc_hit_start) state_d = pc_hit_stop ? ST_DRAINING : ST_TRACING;
            end
            ST_TRACING: begin
                if (!arm_q || pc_hit_stop) state_d = ST_DRAINING;
            end
            ST_DRAINING: begin
                if (fifo_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. arm is dropped on entering DRAINING so a finished
    // session parks in IDLE instead of immediately re-arming.
    always_comb begin
        capture = 1'b0;
        case (state_q)
            ST_ARMED:   capture = qualify && arm_q && pc_hit_start;
            ST_TRACING: capture = qualify;
            default:    capture = 1'b0;
        endcase
        arm_clr = (state_q != ST_DRAINING) && (state_d == ST_DRAINING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q      <= 1'b0;
            trig_en_q  <= 1'b0;
            dedup_q    <= 1'b0;
            filter_q   <= FILT_ALL;
            start_q    <= '0;
            stop_q     <= '0;
            interval_q <= '0;
        end else begin
            if (wr_ctrl) begin
                arm_q     <= ctrl_wdata[CTRL_ARM];
                trig_en_q <= ctrl_wdata[CTRL_TRIG_EN];
                dedup_q   <= ctrl_wdata[CTRL_DEDUP];
                filter_q  <= filter_e'(ctrl_wdata[CTRL_FILT_HI:CTRL_FILT_LO]);
            end else if (arm_clr) begin
                arm_q <= 1'b0;
            end
            if (wr_fire && (ctrl_addr == ADDR_START)) start_q    <= XLEN'(ctrl_wdata);
            if (wr_fire && (ctrl_addr == ADDR_STOP))  stop_q     <= XLEN'(ctrl_wdata);
            if (wr_fire && (ctrl_addr == ADDR_TLAST)) interval_q <= ctrl_wdata[31:0];
        end
    end

    assign fifo_pop  = M_AXIS_tvalid && M_AXIS_tready;
    assign fifo_push = capture && (!fifo_full || fifo_pop);
    assign drop      = capture && fifo_full && !fifo_pop;

    cms_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .data_i      ({instr, pc}),
        .pop_i       (fifo_pop),
        .mark_tail_i (flush_pulse),
        .data_o      (fifo_rdata),
        .mark_o      (fifo_mark),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc_q  <= '0;
            dropped_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (capture) last_pc_q <= pc;
            if (drop_clr)
                dropped_q <= '0;
            else if (drop && (dropped_q != 32'hFFFF_FFFF))
                dropped_q <= dropped_q + 32'd1;
            if (fifo_pop)
                beat_cnt_q <= tlast_int ? 32'd0 : beat_cnt_q + 32'd1;
        end
    end

    // In DRAINING nothing is pushed, so a single remaining entry is the final beat.
    assign int_hit   = (interval_q != 32'd0) && (beat_cnt_q == interval_q - 32'd1);
    assign tlast_int = int_hit || fifo_mark ||
                       ((state_q == ST_DRAINING) && (fifo_count == CNT_W'(1)));

    assign M_AXIS_tvalid = !fifo_empty;
    assign M_AXIS_tdata  = fifo_empty ? '0 : AXI_DATA_WIDTH'(fifo_rdata);
    assign M_AXIS_tlast  = !fifo_empty && tlast_int;
    assign dropped_count = dropped_q;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_cms_trace_streamer.sv
module tb_cms_trace_streamer;

    localparam int XLEN  = 64;
    localparam int DW    = 96;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            pc_valid, en;
    logic [7:0]      ctrl_addr;
    logic [63:0]     ctrl_wdata;
    logic            ctrl_write_enable;
    logic            tvalid, tready, tlast, busy;
    logic [DW-1:0]   tdata;
    logic [31:0]     dropped_count;

    always #5 clk = ~clk;

    cms_trace_streamer #(
        .XLEN (XLEN), .AXI_DATA_WIDTH (DW), .FIFO_DEPTH (DEPTH),
        .CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED (1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .instr (instr), .pc (pc), .pc_valid (pc_valid),
        .en (en), .ctrl_addr (ctrl_addr), .ctrl_wdata (ctrl_wdata),
        .ctrl_write_enable (ctrl_write_enable), .M_AXIS_tvalid (tvalid),
        .M_AXIS_tready (tready), .M_AXIS_tdata (tdata), .M_AXIS_tlast (tlast),
        .dropped_count (dropped_count), .busy (busy)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: session mode 0 idle, 1 waiting for start, 2 tracing, 3 done
    int          m_mode = 0;
    logic [63:0] m_start = '0, m_stop = '0, m_last_pc = '0;
    int          m_filter = 0;
    bit          m_dedup = 0, m_trig = 0;
    int          m_interval = 0, m_cnt = 0;
    bit          m_track_occ = 0;
    int          m_occ = 0, m_drops = 0;
    logic [63:0] exp_pc[$];
    logic [31:0] exp_ins[$];
    bit          exp_last[$];
    int          n_beats = 0;

    // tready source: 0 fixed, 1 random, 2 toggling
    int rdy_mode = 0;
    bit rdy_fixed = 1;

    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 1)      tready = ($urandom_range(0, 1) == 1);
            else if (rdy_mode == 2) tready = !tready;
            else                    tready = rdy_fixed;
        end
    end

    function automatic bit m_filter_ok(int mode, logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (mode == 1) return (op == 7'h63) || (op == 7'h6f) || (op == 7'h67);
        if (mode == 2) return ins != 32'h1050_0073;
        return 1'b1;
    endfunction

    task automatic model_record(input logic [63:0] p, input logic [31:0] ins);
        bit win, stop_hit, cap;
        win = 0; stop_hit = 0;
        if (m_mode == 1 && p == m_start) m_mode = 2;
        if (m_mode == 2) begin
            win = 1;
            if (p == m_stop) begin stop_hit = 1; m_mode = 3; end
        end
        cap = win && m_filter_ok(m_filter, ins) && !(m_dedup && p == m_last_pc);
        if (cap) begin
            m_last_pc = p;
            if (m_track_occ && m_occ >= DEPTH) m_drops++;
            else begin
                exp_pc.push_back(p); exp_ins.push_back(ins); exp_last.push_back(stop_hit);
                if (m_track_occ) m_occ++;
            end
        end
    endtask

    logic [DW-1:0] prev_data;
    bit            prev_stall = 0;

    always @(negedge clk) begin
        logic [DW-1:0] ed;
        bit el;
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall) begin
                chk_eq("hold_tvalid", tvalid, 1);
                chk_eq("hold_tdata", tdata, prev_data);
            end
            if (tvalid && tready) begin
                n_beats++;
                chk_eq("beat_expected", exp_pc.size() != 0, 1);
                if (exp_pc.size() != 0) begin
                    ed = {32'b0, exp_ins[0], exp_pc[0]};
                    el = exp_last[0] || (m_interval != 0 && m_cnt == m_interval - 1);
                    chk_eq("tdata", tdata, ed);
                    chk_eq("tlast", tlast, el);
                    m_cnt = el ? 0 : m_cnt + 1;
                    void'(exp_pc.pop_front()); void'(exp_ins.pop_front()); void'(exp_last.pop_front());
                    if (m_track_occ) m_occ--;
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
        end
    end

    task automatic wr(input logic [7:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        ctrl_addr = a; ctrl_wdata = d; ctrl_write_enable = 1'b1;
        @(posedge clk); #1;
        ctrl_write_enable = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [63:0] p, input logic [31:0] i);
        @(posedge clk); #1;
        pc_valid = v; pc = p; instr = i;
        if (v) model_record(p, i);
    endtask

    task automatic set_interval(input int v);
        wr(8'h03, 64'(v));
        m_interval = v;
    endtask

    task automatic set_window(input logic [63:0] s, input logic [63:0] t);
        wr(8'h01, s); wr(8'h02, t);
        m_start = s; m_stop = t;
    endtask

    function automatic logic [63:0] ctrl_word(bit a, bit trig, bit fl, bit dd, int filt);
        logic [63:0] d;
        logic [1:0]  f;
        f = filt[1:0];
        d = '0;
        d[0] = a; d[1] = trig; d[2] = fl; d[3] = dd; d[5:4] = f;
        return d;
    endfunction

    task automatic arm(input bit trig, input bit dd, input int filt);
        m_trig = trig; m_dedup = dd; m_filter = filt;
        wr(8'h00, ctrl_word(1, trig, 0, dd, filt));
        m_mode = trig ? 1 : 2;
        repeat (3) @(posedge clk);
    endtask

    task automatic flush();
        wr(8'h00, ctrl_word(1, m_trig, 1, m_dedup, m_filter));
        if (exp_pc.size() != 0) exp_last[exp_last.size() - 1] = 1'b1;
    endtask

    // Callers disarm only with the buffer empty or the stream stalled.
    task automatic disarm();
        wr(8'h00, 64'h0);
        if (m_mode == 2 && exp_pc.size() != 0) exp_last[exp_last.size() - 1] = 1'b1;
        m_mode = 0;
    endtask

    task automatic wait_done(input string tag, input bit want_idle);
        int n;
        n = 0;
        while ((exp_pc.size() != 0 || tvalid || (want_idle && busy)) && n < 600) begin
            @(negedge clk); n++;
        end
        chk_eq({tag, "_queue_empty"}, exp_pc.size(), 0);
        if (want_idle) chk_eq({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        logic [31:0] itab[5];
        rst_n = 1'b0; instr = '0; pc = '0; pc_valid = 0; en = 1;
        ctrl_addr = '0; ctrl_wdata = '0; ctrl_write_enable = 0;
        #12;
        chk_eq("rst_tvalid", tvalid, 0);
        chk_eq("rst_tlast", tlast, 0);
        chk_eq("rst_tdata", tdata, 0);
        chk_eq("rst_dropped", dropped_count, 0);
        chk_eq("rst_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;

        // T1: free-running trace, tlast every 4 beats, capture latency
        rdy_mode = 0; rdy_fixed = 1;
        set_interval(4);
        arm(0, 0, 0);
        drive(1, 64'h8, 32'h13);
        chk_eq("t1_tvalid_before_capture", tvalid, 0);
        drive(1, 64'hC, 32'h13);
        chk_eq("t1_tvalid_latency", tvalid, 1);
        for (int i = 2; i < 8; i++) drive(1, 64'(8 + 4 * i), 32'h13);
        drive(0, 0, 0);
        wait_done("t1", 0);
        disarm();
        wait_done("t1_end", 1);

        // T2: start/stop trigger window
        set_interval(0);
        set_window(64'h20, 64'h30);
        b0 = n_beats;
        arm(1, 0, 0);
        for (int i = 1; i <= 16; i++) drive(1, 64'(4 * i), 32'h13);
        drive(0, 0, 0);
        wait_done("t2", 1);
        chk_eq("t2_beats", n_beats - b0, 5);

        // T3: control-flow filter, then WFI suppression
        b0 = n_beats;
        arm(0, 0, 1);
        drive(1, 64'h200, 32'h0000_0013);
        drive(1, 64'h204, 32'h0000_006f);
        drive(1, 64'h208, 32'h0C60_1063);
        drive(1, 64'h20C, 32'h0000_0067);
        drive(1, 64'h210, 32'h0000_00ef);
        drive(1, 64'h214, 32'h0013_0013);
        drive(0, 0, 0);
        wait_done("t3a", 0);
        chk_eq("t3_cflow_beats", n_beats - b0, 4);
        disarm();
        wait_done("t3a_end", 1);
        b0 = n_beats;
        arm(0, 0, 2);
        drive(1, 64'h300, 32'h1050_0073);
        drive(1, 64'h304, 32'h0000_0013);
        drive(1, 64'h308, 32'h1050_0073);
        drive(1, 64'h30C, 32'h0000_0033);
        drive(1, 64'h310, 32'h0000_0013);
        drive(0, 0, 0);
        wait_done("t3b", 0);
        chk_eq("t3_nowfi_beats", n_beats - b0, 3);
        disarm();
        wait_done("t3b_end", 1);

        // T4: flush marks the tail while stalled; disarm drains with tlast
        rdy_fixed = 0;
        b0 = n_beats;
        arm(0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 64'(32'h400 + 4 * i), 32'h13);
        drive(0, 0, 0);
        flush();
        for (int i = 3; i < 5; i++) drive(1, 64'(32'h400 + 4 * i), 32'h13);
        drive(0, 0, 0);
        disarm();
        rdy_fixed = 1;
        wait_done("t4", 1);
        chk_eq("t4_beats", n_beats - b0, 5);

        // T5: overflow, drop count, drain, clear
        rdy_fixed = 0;
        b0 = n_beats;
        arm(0, 0, 0);
        m_track_occ = 1; m_occ = 0; m_drops = 0;
        for (int i = 0; i < 20; i++) drive(1, 64'(32'h500 + 4 * i), 32'h13);
        drive(0, 0, 0);
        repeat (2) @(negedge clk);
        chk_eq("t5_dropped", dropped_count, 4);
        chk_eq("t5_dropped_model", dropped_count, m_drops);
        disarm();
        m_track_occ = 0;
        rdy_fixed = 1;
        wait_done("t5", 1);
        chk_eq("t5_beats", n_beats - b0, 16);
        wr(8'h04, 64'h0);
        @(negedge clk);
        chk_eq("t5_drop_clear", dropped_count, 0);

        // T6: duplicate suppression with a toggling tready
        rdy_mode = 2;
        b0 = n_beats;
        arm(0, 1, 0);
        drive(1, 64'h100, 32'h13);
        drive(1, 64'h100, 32'h13);
        drive(1, 64'h100, 32'h13);
        drive(1, 64'h104, 32'h13);
        drive(0, 0, 0);
        wait_done("t6", 0);
        chk_eq("t6_dedup_beats", n_beats - b0, 2);
        disarm();
        wait_done("t6_end", 1);

        // T7: async reset with buffered records, then a clean restart
        rdy_mode = 0; rdy_fixed = 0;
        arm(0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 64'(32'h600 + 4 * i), 32'h13);
        drive(0, 0, 0);
        @(negedge clk);
        chk_eq("t7_tvalid_pre", tvalid, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_eq("t7_rst_tvalid", tvalid, 0);
        chk_eq("t7_rst_tlast", tlast, 0);
        chk_eq("t7_rst_dropped", dropped_count, 0);
        chk_eq("t7_rst_busy", busy, 0);
        exp_pc.delete(); exp_ins.delete(); exp_last.delete();
        m_mode = 0; m_cnt = 0; m_last_pc = '0; m_interval = 0;
        m_start = '0; m_stop = '0; m_filter = 0; m_dedup = 0; m_trig = 0;
        #20;
        @(negedge clk); rst_n = 1'b1;
        rdy_fixed = 1;
        b0 = n_beats;
        set_interval(2);
        set_window(64'h708, 64'h714);
        arm(1, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 64'(32'h700 + 4 * i), 32'h13);
        drive(0, 0, 0);
        wait_done("t7", 1);
        chk_eq("t7_beats", n_beats - b0, 4);

        // T8: randomized sessions
        rdy_mode = 1;
        for (int k = 0; k < 8; k++) begin
            int s, t, reps;
            logic [63:0] base;
            base = 64'(32'h1000 * (k + 1));
            s = $urandom_range(0, 5);
            t = s + $urandom_range(0, 6);
            set_interval($urandom_range(0, 5));
            set_window(base + 64'(4 * s), base + 64'(4 * t));
            arm(1, $urandom_range(0, 1) == 1, $urandom_range(0, 3));
            itab[0] = 32'h0000_0013; itab[1] = 32'h1050_0073; itab[2] = 32'h00C5_8663;
            itab[3] = 32'h0000_80E7; itab[4] = $urandom;
            for (int i = 0; i < 12; i++) begin
                reps = ($urandom_range(0, 3) == 0) ? 2 : 1;
                for (int r = 0; r < reps; r++) begin
                    if ($urandom_range(0, 2) == 0) drive(0, 0, 0);
                    if (i == t) drive(1, base + 64'(4 * i), 32'h0080_006f);
                    else        drive(1, base + 64'(4 * i), itab[$urandom_range(0, 4)]);
                end
            end
            drive(0, 0, 0);
            wait_done("t8", 1);
        end

        chk_eq("final_queue_empty", exp_pc.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/cms_trace_streamer.md
Name: cms_trace_streamer

Overview:
Parametrised next-generation trace capture block for the continuous monitoring system. It samples retired {pc, instr} pairs and filters them by instruction class, pc trigger window and duplicate suppression. Accepted records are buffered in an internal FIFO and streamed to the DMA FIFO over AXI-Stream, with a programmable tlast interval, forced tlast on flush/stop, and a drop counter for overflow visibility.

Parameters:
XLEN, 64, pc width
AXI_DATA_WIDTH, 96, tdata width; must be >= XLEN+32; unused upper bits are driven 0
FIFO_DEPTH, 16, internal buffer entries; power of 2, >= 2
CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED, 1, 1 = write acts on the rising edge of ctrl_write_enable; 0 = acts on every cycle it is high

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instr  in  32  retired instruction
pc  in  XLEN  retired pc
pc_valid  in  1  pc/instr valid this cycle
en  in  1  global enable; 0 blocks capture but not draining
ctrl_addr  in  8  control register address
ctrl_wdata  in  64  control write data
ctrl_write_enable  in  1  control write strobe
M_AXIS_tvalid  out  1  stream valid
M_AXIS_tready  in  1  stream ready
M_AXIS_tdata  out  AXI_DATA_WIDTH  {zero pad, instr, pc}; pc in bits [XLEN-1:0]
M_AXIS_tlast  out  1  packet end
dropped_count  out  32  records lost to FIFO full; saturates at 0xFFFFFFFF
busy  out  1  state != IDLE or FIFO not empty

Behaviour:
- Reset (async, rst_n=0): FIFO emptied; state IDLE; tvalid/tlast/tdata/dropped_count/busy = 0; registers: CTRL=0, START=0, STOP=0, TLAST_INTERVAL=0, last_pc=0.
- Registers: 0x00 CTRL (bit0 arm, bit1 trigger_en, bit2 flush (self-clearing pulse), bit3 dedup_en, bits[5:4] filter: 0 all, 1 control-flow only (opcode 1100011/1101111/1100111), 2 all except WFI (0x10500073)); 0x01 START_ADDR; 0x02 STOP_ADDR; 0x03 TLAST_INTERVAL[31:0]; 0x04 any write clears dropped_count. Other addresses are ignored.
- States: IDLE -> (arm=1) ARMED if trigger_en, else TRACING; ARMED -> TRACING on a valid pc == START_ADDR (that record is captured); TRACING -> DRAINING on a valid pc == STOP_ADDR (that record is captured) or on arm written 0; DRAINING -> IDLE when the FIFO is empty after the final beat. If START_ADDR == STOP_ADDR, the trigger record is captured and the block goes straight to DRAINING.
- Capture condition: state TRACING (or the trigger cycle) & pc_valid & en & the filter passes & !(dedup_en & pc == last_pc). last_pc updates on every accepted record.
- Push at the clk edge of the capture cycle. tvalid rises the next cycle if the FIFO was empty (1-cycle latency). Accepted throughput is 1 record/cycle.
- Full FIFO: the push is accepted if a pop handshake occurs in the same cycle. Otherwise the record is dropped and dropped_count increments (saturating). A clear and a drop in the same cycle: clear wins, count = 0.
- AXI: tdata/tvalid are held stable while tvalid & !tready. Pop on tvalid & tready.
- tlast: beat_cnt counts handshakes. tlast = 1 when beat_cnt == TLAST_INTERVAL-1, or when the beat is the last entry in the FIFO while DRAINING or while a flush is pending. beat_cnt resets to 0 after each tlast beat. TLAST_INTERVAL = 0 means tlast only on drain/flush.
- Flush: marks the current FIFO tail entry as needing tlast. If the FIFO is empty, flush has no effect. State is unchanged.
- Changing TLAST_INTERVAL mid-packet takes effect from the next comparison. If beat_cnt is already past the new value, no tlast occurs until a wrap or a drain.
- Async reset mid-packet discards all buffered data; no tlast is emitted.

Decomposition:
- Package cms_pkg: register address constants, CTRL bit indices, filter-mode enum, state enum, RISC-V opcode/WFI constants.
- One sub-module: cms_sync_fifo (parametrised width/depth, full/empty/count, tlast-mark bit stored per entry).

Test Plan:
- trigger_en=0, filter=all, TLAST_INTERVAL=4, tready=1, 8 consecutive valid pcs 0x8..0x24 -> 8 beats, tdata[63:0] matches each pc, tlast on beats 4 and 8, first tvalid 1 cycle after the first capture.
- trigger_en=1, START=0x20, STOP=0x30, pc stepping 0x4..0x40 -> first beat pc=0x20, last beat pc=0x30 with tlast=1, then busy=0.
- filter=1, instr sequence nop, 0x0000006f, 0x0C601063, 0x00000067, 0x000000ef, 0x00130013 -> exactly 4 beats, carrying instrs 6f, 0C601063, 67, ef. filter=2 with two WFIs -> WFIs absent from the stream.
- FIFO_DEPTH=16, tready=0, 20 valid records -> 16 buffered, dropped_count=4. Then tready=1 -> 16 beats drain. Write 0x04 -> dropped_count=0.
- dedup_en=1, pc held at 0x100 for 3 valid cycles then 0x104 -> 2 beats. tready toggling each cycle -> tdata stable while stalled.
- rst_n pulled low mid-packet with 5 entries buffered -> tvalid=0 immediately (async), dropped_count=0, state IDLE; re-arm produces a clean stream.
